// File: rtl/wm_phase_timer.sv
// wm_phase_timer: programmable per-phase countdown timer for the washing
// machine controller. A 1 s tick is derived from Clk with a divisor chosen
// by Clk_Freq. A loaded duration counts down to zero with pause and abort.
//
// Optional feature: define WM_PHASE_TIMER_MIN_TICK_EN to add a
// seconds-in-minute counter that drives Min_Tick once every 60 seconds.
// When the macro is undefined, Min_Tick is tied low and no counter is built.
module wm_phase_timer #(
    parameter int PRESC_W = 24,
    parameter int SEC_W   = 12,
    parameter int DIV0    = 1000000,
    parameter int DIV1    = 2000000,
    parameter int DIV2    = 4000000,
    parameter int DIV3    = 8000000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       Clk_Freq,
    input  logic             Start,
    input  logic [SEC_W-1:0] Duration,
    input  logic             Pause,
    input  logic             Abort,
    output logic             Busy,
    output logic             Paused,
    output logic             Sec_Tick,
    output logic [SEC_W-1:0] Remaining,
    output logic             Done,
    output logic             Min_Tick
);

    // The divisor register holds divisor-1. That way a divisor of
    // 2^PRESC_W still fits in PRESC_W bits, and the terminal-count test
    // is a direct equality against the prescaler.
    localparam logic [PRESC_W-1:0] DIV0_M1 = PRESC_W'(DIV0 - 1);
    localparam logic [PRESC_W-1:0] DIV1_M1 = PRESC_W'(DIV1 - 1);
    localparam logic [PRESC_W-1:0] DIV2_M1 = PRESC_W'(DIV2 - 1);
    localparam logic [PRESC_W-1:0] DIV3_M1 = PRESC_W'(DIV3 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] div_m1_q, div_m1_d;
    logic [SEC_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               paused_q, paused_d;
    logic               sec_tick_q, sec_tick_d;
    logic               done_q, done_d;
    logic [PRESC_W-1:0] div_sel;

`ifdef WM_PHASE_TIMER_MIN_TICK_EN
    logic [5:0]         sec_cnt_q, sec_cnt_d;
    logic               min_tick_q, min_tick_d;
`endif

    // Divisor for the frequency currently selected; latched only on Start.
    always_comb begin
        case (Clk_Freq)
            2'b00:   div_sel = DIV0_M1;
            2'b01:   div_sel = DIV1_M1;
            2'b10:   div_sel = DIV2_M1;
            default: div_sel = DIV3_M1;
        endcase
    end

    // Next-state logic. Priority: Abort > Start > Pause > terminal count.
    // Start is only meaningful in IDLE, and Abort/Pause only while busy,
    // so each state only looks at the inputs that can affect it.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        div_m1_d   = div_m1_q;
        rem_d      = rem_q;
        sec_tick_d = 1'b0;
        done_d     = 1'b0;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
        sec_cnt_d  = sec_cnt_q;
        min_tick_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Duration != '0) begin
                        rem_d    = Duration;
                        presc_d  = '0;
                        div_m1_d = div_sel;
                        state_d  = ST_RUN;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
                        sec_cnt_d = '0;
`endif
                    end else begin
                        // A zero-length phase completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN, ST_HOLD: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    presc_d = '0;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
                    sec_cnt_d = '0;
`endif
                end else if (Pause) begin
                    // Everything freezes; a coincident terminal count is
                    // deferred, so the prescaler stays at divisor-1.
                    state_d = ST_HOLD;
                end else begin
                    // Leaving HOLD counts on the same edge, so the pause
                    // costs exactly as many cycles as Pause was high.
                    state_d = ST_RUN;
                    if (presc_q == div_m1_q) begin
                        presc_d    = '0;
                        sec_tick_d = 1'b1;
                        if (rem_q != '0) begin
                            rem_d = rem_q - 1'b1;
                        end
                        if (rem_q == SEC_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
                        if (sec_cnt_q == 6'd59) begin
                            sec_cnt_d  = '0;
                            min_tick_d = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 1'b1;
                        end
`endif
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
                presc_d = '0;
            end
        endcase
        busy_d   = (state_d != ST_IDLE);
        paused_d = (state_d == ST_HOLD);
    end

    // State and registered outputs; reset clears everything, so a reset
    // mid-run simply drops the phase without a Done.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            div_m1_q   <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            sec_tick_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
            sec_cnt_q  <= '0;
            min_tick_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            div_m1_q   <= div_m1_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
            sec_tick_q <= sec_tick_d;
            done_q     <= done_d;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
            sec_cnt_q  <= sec_cnt_d;
            min_tick_q <= min_tick_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Paused    = paused_q;
    assign Sec_Tick  = sec_tick_q;
    assign Remaining = rem_q;
    assign Done      = done_q;
`ifdef WM_PHASE_TIMER_MIN_TICK_EN
    assign Min_Tick  = min_tick_q;
`else
    assign Min_Tick  = 1'b0;
`endif

endmodule
